// File: rtl/nandc_ecc_corr.sv
// NAND page ECC checker/corrector: buffers one page, compares the computed Hamming ECC with the stored ECC, then replays the page.
// Optional build macro NANDC_ECC_CORR_EN flips the located bit during replay when a single data-bit error is correctable.
module nandc_ecc_corr #(
    parameter int WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic        sof_i,
    input  logic        eof_i,
    output logic        in_ready_o,
    input  logic [23:0] ecc_i,
    input  logic        ecc_valid_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        sof_o,
    output logic        eof_o,
    input  logic        ready_i,
    output logic        status_valid_o,
    output logic [1:0]  status_o,
    output logic [6:0]  err_addr_o,
    output logic [4:0]  err_bit_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        WAIT_ECC = 3'd2,
        CHECK    = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    localparam logic [1:0] ST_NONE   = 2'd0;
    localparam logic [1:0] ST_CORR   = 2'd1;
    localparam logic [1:0] ST_ECCERR = 2'd2;
    localparam logic [1:0] ST_UNCORR = 2'd3;
    localparam logic [6:0] LAST_ADDR = 7'(WORDS - 1);

    // Each set bit at index {addr,bit} toggles the odd half with the index and the even half with its complement.
    function automatic logic [23:0] word_ecc(input logic [31:0] d, input logic [6:0] a);
        logic [23:0] e;
        e = 24'd0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                e[23:12] = e[23:12] ^ {a, i[4:0]};
                e[11:0]  = e[11:0] ^ ~{a, i[4:0]};
            end else begin
                e = e;
            end
        end
        return e;
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  wr_ptr_q, wr_ptr_d;
    logic [6:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]  len_q, len_d;
    logic [23:0] comp_q, comp_d;
    logic [23:0] stored_q, stored_d;
    logic [1:0]  status_q, status_d;
    logic        status_valid_q, status_valid_d;
    logic [6:0]  err_addr_q, err_addr_d;
    logic [4:0]  err_bit_q, err_bit_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;

    logic [31:0] mem_q [WORDS];
    logic        mem_we_s;
    logic [6:0]  mem_addr_s;
    logic [31:0] mem_wdata_s;

    logic        accept_s;
    logic [23:0] synd_s;
    logic [11:0] fold_s;
    logic [1:0]  class_s;
    logic [31:0] rd_word_s;

    assign accept_s = valid_i && in_ready_q;

    // Syndrome classification: a single data-bit error makes the two halves exact complements.
    always_comb begin
        synd_s  = comp_q ^ stored_q;
        fold_s  = synd_s[23:12] ^ synd_s[11:0];
        class_s = ST_UNCORR;
        if (synd_s == 24'd0) begin
            class_s = ST_NONE;
        end else if ((fold_s == 12'hFFF) && ({1'b0, synd_s[23:17]} < len_q)) begin
            class_s = ST_CORR;
        end else if ((synd_s & (synd_s - 24'd1)) == 24'd0) begin
            class_s = ST_ECCERR;
        end else begin
            class_s = ST_UNCORR;
        end
    end

    // Replay word fetch, with optional in-flight correction of the located bit.
    always_comb begin
        rd_word_s = mem_q[rd_ptr_q];
`ifdef NANDC_ECC_CORR_EN
        if ((status_q == ST_CORR) && (rd_ptr_q == err_addr_q)) begin
            rd_word_s[err_bit_q] = ~mem_q[rd_ptr_q][err_bit_q];
        end else begin
            rd_word_s = mem_q[rd_ptr_q];
        end
`endif
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        len_d          = len_q;
        comp_d         = comp_q;
        stored_d       = stored_q;
        status_d       = status_q;
        status_valid_d = 1'b0;
        err_addr_d     = err_addr_q;
        err_bit_d      = err_bit_q;
        data_d         = data_q;
        valid_d        = valid_q;
        sof_d          = sof_q;
        eof_d          = eof_q;
        mem_we_s       = 1'b0;
        mem_addr_s     = wr_ptr_q;
        mem_wdata_s    = data_i;
        case (state_q)
            IDLE, FILL: begin
                if (accept_s && sof_i) begin
                    mem_we_s   = 1'b1;
                    mem_addr_s = 7'd0;
                    comp_d     = word_ecc(data_i, 7'd0);
                    wr_ptr_d   = 7'd1;
                    if (eof_i || (LAST_ADDR == 7'd0)) begin
                        len_d   = 8'd1;
                        state_d = WAIT_ECC;
                    end else begin
                        state_d = FILL;
                    end
                end else if (accept_s && (state_q == FILL)) begin
                    mem_we_s = 1'b1;
                    comp_d   = comp_q ^ word_ecc(data_i, wr_ptr_q);
                    wr_ptr_d = wr_ptr_q + 7'd1;
                    if (eof_i || (wr_ptr_q == LAST_ADDR)) begin
                        len_d   = {1'b0, wr_ptr_q} + 8'd1;
                        state_d = WAIT_ECC;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            WAIT_ECC: begin
                if (ecc_valid_i) begin
                    stored_d = ecc_i;
                    state_d  = CHECK;
                end else begin
                    state_d = WAIT_ECC;
                end
            end
            CHECK: begin
                status_valid_d = 1'b1;
                status_d       = class_s;
                err_addr_d     = (class_s == ST_CORR) ? synd_s[23:17] : 7'd0;
                err_bit_d      = (class_s == ST_CORR) ? synd_s[16:12] : 5'd0;
                rd_ptr_d       = 7'd0;
                state_d        = DRAIN;
            end
            DRAIN: begin
                if (valid_q && ready_i && eof_q) begin
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eof_d   = 1'b0;
                    state_d = IDLE;
                end else if (!valid_q || ready_i) begin
                    valid_d  = 1'b1;
                    data_d   = rd_word_s;
                    sof_d    = (rd_ptr_q == 7'd0);
                    eof_d    = ({1'b0, rd_ptr_q} == (len_q - 8'd1));
                    rd_ptr_d = rd_ptr_q + 7'd1;
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE) || (state_d == FILL);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wr_ptr_q       <= 7'd0;
            rd_ptr_q       <= 7'd0;
            len_q          <= 8'd0;
            comp_q         <= 24'd0;
            stored_q       <= 24'd0;
            status_q       <= ST_NONE;
            status_valid_q <= 1'b0;
            err_addr_q     <= 7'd0;
            err_bit_q      <= 5'd0;
            data_q         <= 32'd0;
            valid_q        <= 1'b0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            len_q          <= len_d;
            comp_q         <= comp_d;
            stored_q       <= stored_d;
            status_q       <= status_d;
            status_valid_q <= status_valid_d;
            err_addr_q     <= err_addr_d;
            err_bit_q      <= err_bit_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            sof_q          <= sof_d;
            eof_q          <= eof_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
        end
    end

    // Page buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign data_o         = data_q;
    assign valid_o        = valid_q;
    assign sof_o          = sof_q;
    assign eof_o          = eof_q;
    assign status_valid_o = status_valid_q;
    assign status_o       = status_q;
    assign err_addr_o     = err_addr_q;
    assign err_bit_o      = err_bit_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_nandc_ecc_corr.sv
// Randomized bench for nandc_ecc_corr against a bit-level parity model of the page ECC and a queue of expected replay words.
module tb_nandc_ecc_corr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_i = 32'd0;
    logic        valid_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
    logic        in_ready_o;
    logic [23:0] ecc_i = 24'd0;
    logic        ecc_valid_i = 1'b0;
    logic [31:0] data_o;
    logic        valid_o, sof_o, eof_o;
    logic        ready_i = 1'b1;
    logic        status_valid_o;
    logic [1:0]  status_o;
    logic [6:0]  err_addr_o;
    logic [4:0]  err_bit_o;
    logic        busy_o;

    nandc_ecc_corr #(.WORDS(128)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sof_i(sof_i), .eof_i(eof_i),
        .in_ready_o(in_ready_o), .ecc_i(ecc_i), .ecc_valid_i(ecc_valid_i), .data_o(data_o),
        .valid_o(valid_o), .sof_o(sof_o), .eof_o(eof_o), .ready_i(ready_i),
        .status_valid_o(status_valid_o), .status_o(status_o), .err_addr_o(err_addr_o),
        .err_bit_o(err_bit_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] pg [128];
    logic [33:0] exp_q [$];
    logic [31:0] out_words [128];
    int          pop_cnt = 0;
    bit          st_pending = 1'b0;
    logic [1:0]  exp_st = 2'd0, held_st = 2'd0;
    logic [6:0]  exp_addr = 7'd0, held_addr = 7'd0;
    logic [4:0]  exp_bit = 5'd0, held_bit = 5'd0;
    int          ready_mode = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ECC from the parity definition: odd[k] covers bits whose index has bit k set, even[k] the rest.
    function automatic logic [23:0] model_ecc(input int len);
        logic [23:0] e;
        bit od, ev;
        int idx;
        e = 24'd0;
        for (int k = 0; k < 12; k++) begin
            od = 1'b0;
            ev = 1'b0;
            for (int w = 0; w < len; w++) begin
                for (int b = 0; b < 32; b++) begin
                    idx = w * 32 + b;
                    if (pg[w][b]) begin
                        if (((idx >> k) & 1) == 1) od = ~od;
                        else ev = ~ev;
                    end
                end
            end
            e[12 + k] = od;
            e[k] = ev;
        end
        return e;
    endfunction

    function automatic logic [1:0] model_status(input logic [23:0] s, input int len);
        if (s == 24'd0) return 2'd0;
        if (((s[23:12] ^ s[11:0]) == 12'hFFF) && (int'(s[23:17]) < len)) return 2'd1;
        if ($countones(s) == 1) return 2'd2;
        return 2'd3;
    endfunction

    // Downstream ready pattern: always, random, or toggling.
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) ready_i = 1'b1;
        else if (ready_mode == 1) ready_i = 1'($urandom_range(0, 1));
        else ready_i = ~ready_i;
    end

    // Compare process: status strobe, held status, stall stability and replay order.
    initial begin
        logic        prev_stall;
        logic [33:0] prev_out, e;
        prev_stall = 1'b0;
        prev_out = 34'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (status_valid_o) begin
                    chk("status_expected", 32'(st_pending), 32'd1);
                    held_st = exp_st;
                    held_addr = exp_addr;
                    held_bit = exp_bit;
                    st_pending = 1'b0;
                end
                chk("status_o", 32'(status_o), 32'(held_st));
                chk("err_addr_o", 32'(err_addr_o), 32'(held_addr));
                chk("err_bit_o", 32'(err_bit_o), 32'(held_bit));
                if (prev_stall) begin
                    chk("stall_valid", 32'(valid_o), 32'd1);
                    chk("stall_data", data_o, prev_out[31:0]);
                    chk("stall_sof_eof", 32'({sof_o, eof_o}), 32'(prev_out[33:32]));
                end
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid_o", 32'(valid_o), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_o", data_o, e[31:0]);
                        chk("sof_eof", 32'({sof_o, eof_o}), 32'(e[33:32]));
                        if (pop_cnt < 128) out_words[pop_cnt] = data_o;
                        pop_cnt++;
                    end
                end
                prev_stall = valid_o && !ready_i;
                prev_out = {sof_o, eof_o, data_o};
            end
        end
    end

    task automatic drive_word(input logic [31:0] d, input logic s, input logic e, input logic junk);
        data_i = d;
        sof_i = s;
        eof_i = e;
        valid_i = 1'b1;
        if (junk) begin
            ecc_valid_i = 1'b1;
            ecc_i = 24'($urandom);
        end
        @(negedge clk);
        chk("in_ready_o", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sof_i = 1'b0;
        eof_i = 1'b0;
        ecc_valid_i = 1'b0;
    endtask

    // Load model expectations for pg[0..len-1], then push the page and its stored ECC.
    task automatic start_page(input int len, input logic [23:0] ecc, input bit extras, input bit use_eof);
        logic [23:0] s;
        logic [31:0] w;
        s = model_ecc(len) ^ ecc;
        exp_st = model_status(s, len);
        exp_addr = (exp_st == 2'd1) ? s[23:17] : 7'd0;
        exp_bit = (exp_st == 2'd1) ? s[16:12] : 5'd0;
        exp_q.delete();
        pop_cnt = 0;
        for (int i = 0; i < len; i++) begin
            w = pg[i];
`ifdef NANDC_ECC_CORR_EN
            if ((exp_st == 2'd1) && (i == int'(exp_addr))) w[exp_bit] = ~w[exp_bit];
`endif
            exp_q.push_back({(i == 0), (i == len - 1), w});
        end
        st_pending = 1'b1;
        if (extras) begin
            drive_word(32'($urandom), 1'b0, 1'b0, 1'b0);
            drive_word(32'($urandom), 1'b1, 1'b0, 1'b1);
            drive_word(32'($urandom), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < len; i++) begin
            drive_word(pg[i], (i == 0), (i == len - 1) && use_eof, extras && (i % 7 == 3) && (i != len - 1));
        end
        ecc_i = ecc;
        ecc_valid_i = 1'b1;
        @(posedge clk);
        #1;
        ecc_valid_i = 1'b0;
        chk("busy_during_page", 32'(busy_o), 32'd1);
    endtask

    task automatic finish_page();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || st_pending) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("page_done_in_time", 32'(cyc < 3000), 32'd1);
        exp_q.delete();
        st_pending = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_after_page", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 128; i++) pg[i] = 32'd0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 128; i++) pg[i] = $urandom;
    endtask

    initial begin
        int len, mode, idx;
        logic [23:0] ce;
        #2;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_busy_o", 32'(busy_o), 32'd0);
        chk("rst_status", 32'({status_valid_o, status_o}), 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        fill_zero();
        chk("model_zero_ecc", 32'(model_ecc(128)), 32'd0);
        start_page(128, 24'd0, 1'b0, 1'b1);
        finish_page();
        chk("zero_page_status", 32'(held_st), 32'd0);

        pg[5] = 32'h8;
        chk("model_S_word5", 32'(model_ecc(128)), 32'h0A3F5C);
        start_page(128, 24'd0, 1'b0, 1'b0);
        finish_page();
        chk("corr_status", 32'(held_st), 32'd1);
        chk("corr_addr", 32'(held_addr), 32'd5);
        chk("corr_bit", 32'(held_bit), 32'd3);
`ifdef NANDC_ECC_CORR_EN
        chk("corr_word5", out_words[5], 32'd0);
`else
        chk("corr_word5", out_words[5], 32'h8);
`endif

        fill_zero();
        start_page(128, 24'h000400, 1'b0, 1'b1);
        finish_page();
        chk("eccerr_status", 32'(held_st), 32'd2);
        chk("eccerr_addr_bit", 32'({held_addr, held_bit}), 32'd0);

        pg[0] = 32'h3;
        chk("model_word0_3", 32'(model_ecc(128)), 32'h001001);
        start_page(128, 24'd0, 1'b0, 1'b1);
        finish_page();
        chk("uncorr_status", 32'(held_st), 32'd3);
        chk("uncorr_word0", out_words[0], 32'h3);

        fill_rand();
        ready_mode = 2;
        start_page(4, model_ecc(4), 1'b1, 1'b1);
        finish_page();
        chk("four_word_count", 32'(pop_cnt), 32'd4);
        chk("four_word_w3", out_words[3], pg[3]);

        // Reset in the middle of replay abandons the page.
        ready_mode = 0;
        fill_rand();
        start_page(128, model_ecc(128), 1'b0, 1'b1);
        for (int c = 0; c < 2000 && pop_cnt < 60; c++) @(negedge clk);
        chk("reached_word60", 32'(pop_cnt >= 60), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_o", 32'({valid_o, sof_o, eof_o}), 32'd0);
        chk("arst_data_o", data_o, 32'd0);
        chk("arst_busy_o", 32'(busy_o), 32'd0);
        chk("arst_status", 32'({status_valid_o, status_o, err_addr_o, err_bit_o}), 32'd0);
        exp_q.delete();
        st_pending = 1'b0;
        held_st = 2'd0;
        held_addr = 7'd0;
        held_bit = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        ready_mode = 1;
        for (int p = 0; p < 12; p++) begin
            fill_rand();
            len = (p == 0) ? 1 : int'($urandom_range(1, 128));
            mode = int'($urandom_range(0, 3));
            ce = model_ecc(len);
            idx = int'($urandom_range(0, len * 32 - 1));
            if (mode == 1) ce = ce ^ {12'(idx), ~12'(idx)};
            else if (mode == 2) ce = ce ^ (24'd1 << $urandom_range(0, 23));
            else if (mode == 3) ce = 24'($urandom);
            start_page(len, ce, (p % 3 == 1), (len < 128) || (p % 2 == 0));
            finish_page();
            if (mode == 1) chk("rand_corr_status", 32'(held_st), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nandc_ecc_corr.md
NANDC_ECC_CORR -- requirements
Module: nandc_ecc_corr

Interface
REQ-001 The block SHALL have parameter WORDS, default 128, meaning maximum page length in 32-bit words (legal 1..128).
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port data_i, input, 32, page data read from flash.
REQ-005 The block SHALL have port valid_i / sof_i / eof_i, input, 1 each, meaning word valid / first word / last word.
REQ-006 The block SHALL have port in_ready_o, output, 1, meaning a word is accepted when valid_i && in_ready_o.
REQ-007 The block SHALL have port ecc_i, input, 24, meaning stored ECC read from spare area, in generator layout (even half [11:0], odd half [23:12]).
REQ-008 The block SHALL have port ecc_valid_i, input, 1, meaning ecc_i valid.
REQ-009 The block SHALL have port data_o / valid_o / sof_o / eof_o, output, 32/1/1/1, meaning replayed page.
REQ-010 The block SHALL have port ready_i, input, 1, meaning downstream accept.
REQ-011 The block SHALL have port status_valid_o, output, 1, meaning one-cycle status strobe.
REQ-012 The block SHALL have port status_o, output, 2: 0 NONE, 1 CORR, 2 ECC_ERR, 3 UNCORR.
REQ-013 The block SHALL have port err_addr_o / err_bit_o, output, 7/5, meaning error word address / bit index.
REQ-014 The block SHALL have port busy_o, output, 1, meaning state != IDLE.

Function
REQ-015 The FSM SHALL use states IDLE, FILL, WAIT_ECC, CHECK, DRAIN.
REQ-016 in_ready_o SHALL be high in IDLE and FILL only.
REQ-017 In IDLE, an accepted word with sof_i SHALL be written to buffer word 0 and enter FILL; accepted words without sof_i SHALL be dropped.
REQ-018 In FILL, each accepted word SHALL be written at the next address and XOR-accumulated into the computed ECC with the same per-word Hamming function as the generator.
REQ-019 sof_i accepted in FILL SHALL discard the partial page and restart at address 0.
REQ-020 An accepted word with eof_i, or the WORDS-th word, SHALL end the page, record length, and enter WAIT_ECC.
REQ-021 In WAIT_ECC, ecc_valid_i SHALL capture ecc_i and enter CHECK; ecc_valid_i in any other state SHALL be ignored.
REQ-022 Syndrome S = computed ^ stored: S==0 -> NONE; S[23:12]^S[11:0]==12'hFFF and S[23:17] < length -> CORR; exactly one bit of S set -> ECC_ERR; otherwise -> UNCORR.
REQ-023 For CORR, err_addr_o SHALL be S[23:17] and err_bit_o SHALL be S[16:12]; otherwise both SHALL be 0.
REQ-024 status_valid_o SHALL pulse one cycle after the CHECK cycle; status_o/err_* SHALL hold until the next status strobe.
REQ-025 DRAIN SHALL replay words 0..length-1 in order, with first valid_o no later than 2 cycles after status_valid_o, sof_o on word 0, and eof_o on the last word.
REQ-026 While valid_o && !ready_i, data_o/sof_o/eof_o SHALL hold stable.
REQ-027 After the last word is accepted, the FSM SHALL return to IDLE on the same edge.

Reset
REQ-028 Reset SHALL force state IDLE; all outputs, counters, and accumulated ECC 0; status_o=NONE.
REQ-029 Reset mid-page or mid-DRAIN SHALL abandon the page without any further valid_o or status strobe; buffer contents need not clear.

Configuration
REQ-030 With NANDC_ECC_CORR_EN defined, DRAIN SHALL invert bit err_bit_o of word err_addr_o when status is CORR.
REQ-031 Without NANDC_ECC_CORR_EN, data SHALL replay unmodified; status reporting SHALL be unchanged.

Verification
REQ-032 128 zero words, ecc_i=0 -> status NONE; 128 zero words out.
REQ-033 Word 5 = 32'h8, others 0, ecc_i=0 -> S=24'h0A3F5C, CORR, err_addr 5, err_bit 3; word 5 out = 0 (with macro), 32'h8 (without).
REQ-034 Zero page, ecc_i=24'h000400 -> ECC_ERR, err_addr/err_bit 0, data unchanged.
REQ-035 Word 0 = 32'h3, ecc_i=0 -> UNCORR; data replayed unmodified.
REQ-036 4-word page (eof on 4th), ready_i toggling every cycle -> 4 words out in order, eof_o on word 3, data stable while stalled.
REQ-037 rst_n low during DRAIN word 60 -> outputs 0 asynchronously, busy_o 0; next page processed normally.
